// File: rtl/ram_bus_master_if.sv
// Core-side request/write/read handshakes plus RAM address/control lines of the RAM bus master.
// The master modport belongs to the bus master; the slave modport is the core/RAM view.
interface ram_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [3:0]  req_len;
   logic [15:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        done;
   logic [7:0]  mem_address;
   logic [2:0]  mem_control;

   modport master (
      input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
      output req_ready, wr_ready, rd_data, rd_valid, busy, done, mem_address, mem_control
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
      input  req_ready, wr_ready, rd_data, rd_valid, busy, done, mem_address, mem_control
   );
endinterface

// File: rtl/ram_bus_master.sv
// Burst sequencer onto the 8-bit address / 16-bit shared-data RAM; read beat READ_LATENCY+2 cycles, write beat 2+.
// Requests are held off (req_ready low) for a whole burst; write beats stall on wr_valid; read data cannot be stalled.
module ram_bus_master #(
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   ram_bus_master_if.master  bus,
   inout  wire  [15:0]       mem_data
);
   typedef enum logic [2:0] {
      IDLE, WR_WAIT, WR_DRIVE, RD_ISSUE, RD_RETURN, DONE
   } state_t;

   localparam logic [2:0] CTL_IDLE  = 3'b000;
   localparam logic [2:0] CTL_WR    = 3'b110;
   localparam logic [2:0] CTL_RD    = 3'b101;
   localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY);

   state_t      state_q;
   logic [7:0]  addr_q, addr_d;
   logic [4:0]  cnt_q, cnt_d, len_init;
   logic [2:0]  wait_q;
   logic [15:0] wdata_q, rd_data_q;
   logic        drive_q, req_ready_q, wr_ready_q, rd_valid_q, busy_q, done_q;
   logic [7:0]  mem_address_q;
   logic [2:0]  mem_control_q;

   assign addr_d   = addr_q + 8'd1;
   assign cnt_d    = cnt_q - 5'd1;
   assign len_init = (bus.req_len == 4'd0) ? 5'd16 : {1'b0, bus.req_len};

   // drive_q is cleared asynchronously, so reset releases the shared bus at once
   assign mem_data = drive_q ? wdata_q : 16'hzzzz;

   assign bus.req_ready   = req_ready_q;
   assign bus.wr_ready    = wr_ready_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_control = mem_control_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         addr_q        <= 8'd0;
         cnt_q         <= 5'd0;
         wait_q        <= 3'd0;
         wdata_q       <= 16'd0;
         rd_data_q     <= 16'd0;
         drive_q       <= 1'b0;
         req_ready_q   <= 1'b1;
         wr_ready_q    <= 1'b0;
         rd_valid_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem_address_q <= 8'd0;
         mem_control_q <= CTL_IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  addr_q      <= bus.req_addr;
                  cnt_q       <= len_init;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.req_write) begin
                     state_q    <= WR_WAIT;
                     wr_ready_q <= 1'b1;
                  end else begin
                     state_q       <= RD_ISSUE;
                     mem_address_q <= bus.req_addr;
                     mem_control_q <= CTL_RD;
                     wait_q        <= WAIT_INIT;
                  end
               end
            end
            WR_WAIT: begin
               if (bus.wr_valid && wr_ready_q) begin
                  state_q       <= WR_DRIVE;
                  wdata_q       <= bus.wr_data;
                  wr_ready_q    <= 1'b0;
                  mem_address_q <= addr_q;
                  mem_control_q <= CTL_WR;
                  drive_q       <= 1'b1;
               end
            end
            WR_DRIVE: begin
               addr_q        <= addr_d;
               cnt_q         <= cnt_d;
               mem_control_q <= CTL_IDLE;
               drive_q       <= 1'b0;
               if (cnt_d == 5'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= WR_WAIT;
                  wr_ready_q <= 1'b1;
               end
            end
            RD_ISSUE: begin
               // read control held READ_LATENCY+1 cycles; data sampled on the last edge
               if (wait_q == 3'd0) begin
                  state_q       <= RD_RETURN;
                  rd_data_q     <= mem_data;
                  rd_valid_q    <= 1'b1;
                  mem_control_q <= CTL_IDLE;
               end else begin
                  wait_q <= wait_q - 3'd1;
               end
            end
            RD_RETURN: begin
               rd_valid_q <= 1'b0;
               addr_q     <= addr_d;
               cnt_q      <= cnt_d;
               if (cnt_d == 5'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q       <= RD_ISSUE;
                  mem_address_q <= addr_d;
                  mem_control_q <= CTL_RD;
                  wait_q        <= WAIT_INIT;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a synchronous one-cycle-latency RAM model on the shared bus.
module tb_ram_bus_master;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ram_bus_master_if bus ();
   wire [15:0] mem_data;

   ram_bus_master #(.READ_LATENCY(1)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .mem_data (mem_data)
   );

   // RAM model: unwritten locations read back as {A5, address}
   bit   [15:0]  ram_mem [256];
   bit   [255:0] ram_written;
   logic [15:0]  ram_q = 16'h0000;
   wire          ram_drv = ~bus.mem_control[1];
   assign mem_data = ram_drv ? ram_q : 16'hzzzz;

   always @(posedge clk) begin
      if (bus.mem_control == 3'b110) begin
         ram_mem[bus.mem_address]     <= mem_data;
         ram_written[bus.mem_address] <= 1'b1;
      end
      if (bus.mem_control == 3'b101)
         ram_q <= ram_written[bus.mem_address] ? ram_mem[bus.mem_address] : {8'hA5, bus.mem_address};
   end

   int n_wr = 0, n_rd_ctl = 0, n_rdv = 0, n_done = 0, n_ctl_bad = 0, n_bus_bad = 0;
   always @(negedge clk) begin
      if (bus.mem_control == 3'b110) n_wr++;
      if (bus.mem_control == 3'b101) n_rd_ctl++;
      if (bus.rd_valid === 1'b1) n_rdv++;
      if (bus.done === 1'b1) n_done++;
      if (bus.mem_control == 3'b111 || bus.mem_control == 3'b011) n_ctl_bad++;
      if (ram_drv && mem_data !== ram_q) n_bus_bad++;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_rd(input logic [7:0] a);
      return (a == 8'h01) ? 16'h00C0 : {8'hA5, a};
   endfunction

   task automatic do_read(input string tag, input logic [7:0] a, input logic [3:0] len, input int beats);
      int rdv0, done0, ctl0, got, ready_hi, busy_lo, addr_bad, done_at;
      logic [7:0] ea;
      bit fin;
      rdv0 = n_rdv; done0 = n_done; ctl0 = n_rd_ctl;
      got = 0; ready_hi = 0; busy_lo = 0; addr_bad = 0; done_at = -1; fin = 1'b0; ea = a;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = len;
      tick();
      bus.req_valid = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         if (bus.busy !== 1'b1) busy_lo++;
         if (bus.req_ready !== 1'b0) ready_hi++;
         if (bus.mem_control == 3'b101 && bus.mem_address !== ea) addr_bad++;
         if (bus.rd_valid === 1'b1) begin
            check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_rd(ea)));
            ea = ea + 8'd1;
            got++;
         end
         if (bus.done === 1'b1) begin
            fin = 1'b1;
            done_at = cyc;
         end else begin
            tick();
         end
      end
      check({tag, "_done_seen"}, 32'(fin), 32'd1);
      check({tag, "_beats"}, got, beats);
      check({tag, "_done_cycle"}, done_at, 3 * beats);
      check({tag, "_addr_seq"}, addr_bad, 0);
      check({tag, "_busy_low"}, busy_lo, 0);
      check({tag, "_req_ready_high"}, ready_hi, 0);
      tick();
      check({tag, "_rdv_count"}, n_rdv - rdv0, beats);
      check({tag, "_rd_ctl_cycles"}, n_rd_ctl - ctl0, 2 * beats);
      check({tag, "_done_count"}, n_done - done0, 1);
      check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [15:0] wdat [4];
      int wr0, done0, waits;
      wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;

      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'h00; bus.req_len = 4'h0;
      bus.wr_data = 16'h0000; bus.wr_valid = 1'b0;
      repeat (3) tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_rd_data", 32'(bus.rd_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mem_address", 32'(bus.mem_address), 32'd0);
      check("rst_mem_control", 32'(bus.mem_control), 32'd0);
      check("rst_mem_data_released", 32'(mem_data), 32'(ram_q));
      reset = 1'b0;
      tick();

      // single write of 00C0 to address 01
      done0 = n_done; wr0 = n_wr;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h01; bus.req_len = 4'd1;
      bus.wr_data = 16'h00C0; bus.wr_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check("w1_busy", 32'(bus.busy), 32'd1);
      check("w1_req_ready", 32'(bus.req_ready), 32'd0);
      check("w1_wr_ready", 32'(bus.wr_ready), 32'd1);
      check("w1_wait_ctl", 32'(bus.mem_control), 32'd0);
      tick();
      bus.wr_valid = 1'b0;
      check("w1_drive_ctl", 32'(bus.mem_control), 32'h6);
      check("w1_drive_addr", 32'(bus.mem_address), 32'h01);
      check("w1_drive_data", 32'(mem_data), 32'h00C0);
      check("w1_drive_wr_ready", 32'(bus.wr_ready), 32'd0);
      tick();
      check("w1_done", 32'(bus.done), 32'd1);
      check("w1_done_busy", 32'(bus.busy), 32'd1);
      check("w1_done_ctl", 32'(bus.mem_control), 32'd0);
      tick();
      check("w1_idle_done", 32'(bus.done), 32'd0);
      check("w1_idle_ready", 32'(bus.req_ready), 32'd1);
      check("w1_wr_cycles", n_wr - wr0, 1);
      check("w1_done_count", n_done - done0, 1);
      check("w1_ram", 32'(ram_mem[8'h01]), 32'h00C0);

      // single read of address 01
      do_read("r1", 8'h01, 4'd1, 1);

      // 4-beat write at 10 with a 3-cycle wr_valid gap before beat 3
      done0 = n_done; wr0 = n_wr;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h10; bus.req_len = 4'd4;
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            bus.wr_valid = 1'b0;
            repeat (3) tick();
            check("w4_gap_wr_ready", 32'(bus.wr_ready), 32'd1);
            check("w4_gap_ctl", 32'(bus.mem_control), 32'd0);
         end
         bus.wr_data = wdat[i]; bus.wr_valid = 1'b1;
         waits = 0;
         do begin
            tick();
            waits++;
         end while (bus.mem_control != 3'b110 && waits < 10);
         check("w4_beat_wait", waits, (i == 0 || i == 2) ? 1 : 2);
         check("w4_beat_addr", 32'(bus.mem_address), 32'(8'h10 + 8'(i)));
         check("w4_beat_data", 32'(mem_data), 32'(wdat[i]));
      end
      bus.wr_valid = 1'b0;
      tick();
      check("w4_done", 32'(bus.done), 32'd1);
      tick();
      check("w4_wr_cycles", n_wr - wr0, 4);
      check("w4_done_count", n_done - done0, 1);
      for (int i = 0; i < 4; i++)
         check("w4_ram", 32'(ram_mem[8'h10 + 8'(i)]), 32'(wdat[i]));

      // wrapping burst FE,FF,00,01 then a 16-beat burst from 00
      do_read("rwrap", 8'hFE, 4'd4, 4);
      do_read("r16", 8'h00, 4'd0, 16);

      // reset during WR_DRIVE of beat 2 of a 4-beat write at 20
      done0 = n_done;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h20; bus.req_len = 4'd4;
      bus.wr_data = 16'h5555; bus.wr_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      bus.wr_data = 16'h6666;
      tick();
      tick();
      check("rm_in_drive", 32'(bus.mem_control), 32'h6);
      check("rm_drive_addr", 32'(bus.mem_address), 32'h21);
      reset = 1'b1;
      #1;
      check("rm_ctl_released", 32'(bus.mem_control), 32'd0);
      check("rm_data_released", 32'(mem_data), 32'(ram_q));
      check("rm_busy", 32'(bus.busy), 32'd0);
      check("rm_req_ready", 32'(bus.req_ready), 32'd1);
      bus.wr_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rm_no_done", n_done - done0, 0);
      check("rm_beat1_written", 32'(ram_mem[8'h20]), 32'h5555);
      check("rm_beat2_not_written", 32'(ram_written[8'h21]), 32'd0);
      do_read("rpost", 8'h01, 4'd1, 1);

      check("ctl_never_illegal", n_ctl_bad, 0);
      check("bus_never_contended", n_bus_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
